// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multicycle RV32I-subset datapath sharing one instruction/data memory.
// Decodes op/funct3/funct7, sequences the datapath and handles mem_ready waits and timeouts.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | decode, precompute branch target OldPC+imm, flag illegal ops
// MEMADR   | compute rs1+imm load/store address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded word to register file
// MEMWRITE | write data memory at ALUOut, strobe held until mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BRANCH   | compare rs1-rs2, take branch from precomputed target

module multicycle_control_fsm #(
   parameter int WAIT_LIMIT  = 0,
   parameter bit SUPPORT_BNE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] ula_src_a,
   output logic [1:0] ula_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] ula_control,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam bit TIMEOUT_EN = (WAIT_LIMIT > 0);
   localparam int WCW        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [WCW-1:0]   r_wait_cnt;
   logic             w_r_ok, w_i_ok, w_b_ok, w_legal;
   logic [2:0]       w_r_alu, w_i_alu;
   logic             w_in_mem_state;
   logic             w_timeout;

   always_comb begin
      w_r_ok  = 1'b0;
      w_r_alu = ALU_ADD;
      case ({funct3, funct7})
         10'b000_0000000: begin w_r_ok = 1'b1; w_r_alu = ALU_ADD; end
         10'b000_0100000: begin w_r_ok = 1'b1; w_r_alu = ALU_SUB; end
         10'b111_0000000: begin w_r_ok = 1'b1; w_r_alu = ALU_AND; end
         10'b110_0000000: begin w_r_ok = 1'b1; w_r_alu = ALU_OR;  end
         10'b010_0000000: begin w_r_ok = 1'b1; w_r_alu = ALU_SLT; end
         default: ;
      endcase

      w_i_ok  = 1'b0;
      w_i_alu = ALU_ADD;
      case (funct3)
         3'b000:  begin w_i_ok = 1'b1; w_i_alu = ALU_ADD; end
         3'b111:  begin w_i_ok = 1'b1; w_i_alu = ALU_AND; end
         3'b110:  begin w_i_ok = 1'b1; w_i_alu = ALU_OR;  end
         3'b100:  begin w_i_ok = 1'b1; w_i_alu = ALU_XOR; end
         default: ;
      endcase

      w_b_ok = (funct3 == 3'b000) || (SUPPORT_BNE && (funct3 == 3'b001));

      case (op)
         OP_LOAD, OP_STORE: w_legal = 1'b1;
         OP_RTYPE:          w_legal = w_r_ok;
         OP_ITYPE:          w_legal = w_i_ok;
         OP_BRANCH:         w_legal = w_b_ok;
         default:           w_legal = 1'b0;
      endcase
   end

   assign w_in_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                           (r_state == S_MEMWRITE);
   // r_wait_cnt counts earlier wait cycles, so the limit hits on wait cycle WAIT_LIMIT
   assign w_timeout = TIMEOUT_EN && w_in_mem_state && !mem_ready &&
                      (r_wait_cnt == WCW'(WAIT_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (!TIMEOUT_EN || !w_in_mem_state || mem_ready || w_timeout || (w_next != r_state))
            r_wait_cnt <= '0;
         else
            r_wait_cnt <= r_wait_cnt + WCW'(1);
      end
   end

   always_comb begin
      w_next      = r_state;
      mem_req     = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      ula_src_a   = 2'b00;
      ula_src_b   = 2'b00;
      ula_control = ALU_ADD;
      retire      = 1'b0;
      illegal     = 1'b0;
      bus_err     = 1'b0;
      state       = r_state;

      case (op)
         OP_STORE:  imm_src = 2'b01;
         OP_BRANCH: imm_src = 2'b10;
         default:   imm_src = 2'b00;
      endcase

      case (r_state)
         S_FETCH: begin
            mem_req    = 1'b1;
            ula_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            ula_src_a = 2'b01;
            ula_src_b = 2'b01;
            if (!w_legal) begin
               illegal = 1'b1;
               w_next  = S_FETCH;
            end else begin
               case (op)
                  OP_LOAD, OP_STORE: w_next = S_MEMADR;
                  OP_RTYPE:          w_next = S_EXECR;
                  OP_ITYPE:          w_next = S_EXECI;
                  default:           w_next = S_BRANCH;
               endcase
            end
         end
         S_MEMADR: begin
            ula_src_a = 2'b10;
            ula_src_b = 2'b01;
            w_next    = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retire    = mem_ready;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXECR: begin
            ula_src_a   = 2'b10;
            ula_control = w_r_alu;
            w_next      = S_ALUWB;
         end
         S_EXECI: begin
            ula_src_a   = 2'b10;
            ula_src_b   = 2'b01;
            ula_control = w_i_alu;
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            ula_src_a   = 2'b10;
            ula_control = ALU_SUB;
            pc_write    = zero ^ (funct3 == 3'b001);
            retire      = 1'b1;
            w_next      = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase

      if (w_timeout) begin
         bus_err = 1'b1;
         w_next  = S_FETCH;
      end

      if (reset) begin
         mem_req     = 1'b0;
         adr_src     = 1'b0;
         mem_write   = 1'b0;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         reg_write   = 1'b0;
         result_src  = 2'b00;
         ula_src_a   = 2'b00;
         ula_src_b   = 2'b00;
         imm_src     = 2'b00;
         ula_control = 3'b000;
         retire      = 1'b0;
         illegal     = 1'b0;
         bus_err     = 1'b0;
         state       = 4'd0;
      end
   end

endmodule
